// File: rtl/bram_scan_ctrl_pkg.sv
// Shared definitions for the BRAM bring-up scanner.
// Holds the scan FSM states and the default RAM geometry and fill pattern, which is also the RAM wrapper's dina.
package bram_scan_ctrl_pkg;

  localparam int SCAN_ADDR_W = 4;
  localparam int SCAN_DATA_W = 8;
  localparam int SCAN_RD_LAT = 2;
  localparam logic [SCAN_DATA_W-1:0] SCAN_PATTERN = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Read-tag delay line: each issued address travels with its valid bit for RD_LAT cycles so it lines up with douta.
// The output is taken straight from the last stage. There is no backpressure: a new tag can be accepted every cycle.
module rd_lat_pipe #(
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              tag_vld,
  input  logic [ADDR_W-1:0] tag_addr,
  output logic              tail_vld,
  output logic [ADDR_W-1:0] tail_addr,
  output logic              pipe_empty
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  always_ff @(posedge Clk) begin
    if (Clear) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= tag_vld;
      addr_q[0] <= tag_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign tail_vld   = vld_q[RD_LAT-1];
  assign tail_addr  = addr_q[RD_LAT-1];
  assign pipe_empty = ~|vld_q;

endmodule

// File: rtl/bram_scan_ctrl.sv
// BRAM self-test sequencer: fills every address with PATTERN, then reads it all back and counts mismatching bytes.
// A scan runs 2*2**ADDR_W+RD_LAT+1 cycles from start to done. There is no backpressure: the RAM always accepts a read or write.
module bram_scan_ctrl
  import bram_scan_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = SCAN_ADDR_W,
  parameter int                DATA_W  = SCAN_DATA_W,
  parameter int                RD_LAT  = SCAN_RD_LAT,
  parameter logic [DATA_W-1:0] PATTERN = SCAN_PATTERN
) (
  input  logic              Clk,
  input  logic              Clear,
  input  logic              start,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  scan_state_t       state;
  logic              tail_vld;
  logic [ADDR_W-1:0] tail_addr;
  logic              pipe_empty;

  // A tag enters the pipe on every cycle in which a read address is driven onto addra.
  rd_lat_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .Clk        (Clk),
    .Clear      (Clear),
    .tag_vld    (state == ST_READ),
    .tag_addr   (addra),
    .tail_vld   (tail_vld),
    .tail_addr  (tail_addr),
    .pipe_empty (pipe_empty)
  );

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state          <= ST_IDLE;
      wea            <= 1'b0;
      addra          <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      rd_valid <= tail_vld;
      done     <= 1'b0;

      if (tail_vld) begin
        rd_data <= douta;
        if (douta != PATTERN) begin
          err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0) first_err_addr <= tail_addr;
        end
      end

      case (state)
        ST_IDLE: begin
          wea  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state          <= ST_WRITE;
            addra          <= '0;
            wea            <= 1'b1;
            busy           <= 1'b1;
            err_cnt        <= '0;
            first_err_addr <= '0;
          end
        end
        ST_WRITE: begin
          if (addra == ADDR_MAX) begin
            state <= ST_READ;
            addra <= '0;
            wea   <= 1'b0;
          end else begin
            addra <= addra + 1'b1;
          end
        end
        ST_READ: begin
          if (addra == ADDR_MAX) state <= ST_DRAIN;
          else                   addra <= addra + 1'b1;
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Scanner bench: three DUTs with RD_LAT 2, 1 and 4 share the same stimulus, and each one drives its own behavioural RAM.
// Expected timing and results come from the scan rules in the specification.
module tb_bram_scan_ctrl;

  localparam int       NI  = 3;
  localparam bit [7:0] PAT = 8'hAA;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 4;
  endfunction

  logic       Clk;
  logic       Clear;
  logic       start;
  logic       wea_w      [NI];
  logic [3:0] addra_w    [NI];
  logic [7:0] douta_w    [NI];
  logic [7:0] rd_data_w  [NI];
  logic       rd_valid_w [NI];
  logic       busy_w     [NI];
  logic       done_w     [NI];
  logic [4:0] err_cnt_w  [NI];
  logic [3:0] fea_w      [NI];

  logic [7:0] fault_xor [16];
  logic [7:0] exp_dat   [16];
  int exp_err, exp_first;
  int n_chk, n_bad;

  int wr_cnt[NI], wr_bad[NI], wr_first[NI], rv_cnt[NI], first_rv[NI], last_rv[NI];
  int done_cnt[NI], done_at1[NI], done_at2[NI], overlap[NI];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = lat_of(g);
    logic [7:0] mem   [16];
    logic [7:0] rpipe [4];

    bram_scan_ctrl #(.RD_LAT(L)) dut (
      .Clk            (Clk),
      .Clear          (Clear),
      .start          (start),
      .wea            (wea_w[g]),
      .addra          (addra_w[g]),
      .douta          (douta_w[g]),
      .rd_data        (rd_data_w[g]),
      .rd_valid       (rd_valid_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .err_cnt        (err_cnt_w[g]),
      .first_err_addr (fea_w[g])
    );

    // RAM whose stored byte is corrupted by fault_xor, then read back with L cycles of latency.
    always @(posedge Clk) begin
      if (wea_w[g]) mem[addra_w[g]] <= PAT ^ fault_xor[addra_w[g]];
      rpipe[0] <= mem[addra_w[g]];
      for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
    end
    assign douta_w[g] = rpipe[L-1];
  end

  function automatic string tg(input string s, input int g);
    return $sformatf("%s_L%0d", s, lat_of(g));
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode 0: clean RAM, 1: bytes at addresses 5 and 12 read back as 8'h2A, 2: random corruption
  task automatic set_faults(input int mode);
    exp_err   = 0;
    exp_first = 0;
    for (int a = 0; a < 16; a++) begin
      fault_xor[a] = 8'h00;
      if (mode == 1 && (a == 5 || a == 12)) fault_xor[a] = 8'h80;
      if (mode == 2 && $urandom_range(3, 0) == 0) fault_xor[a] = 8'($urandom_range(255, 1));
      exp_dat[a] = PAT ^ fault_xor[a];
      if (exp_dat[a] != PAT) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
  endtask

  // Cycle c drives start/Clear so they are sampled at edge c, and observes the outputs 1 time unit after that edge.
  task automatic run(input int ncyc, input int hold, input int x1, input int x2, input int clr);
    for (int g = 0; g < NI; g++) begin
      wr_cnt[g] = 0;   wr_bad[g] = 0;    wr_first[g] = -1;
      rv_cnt[g] = 0;   first_rv[g] = -1; last_rv[g] = -1;
      done_cnt[g] = 0; done_at1[g] = -1; done_at2[g] = -1; overlap[g] = 0;
    end
    for (int c = 0; c < ncyc; c++) begin
      start = (c <= hold) || (c == x1) || (c == x2);
      Clear = (c == clr);
      @(posedge Clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        int lg;
        lg = lat_of(g);
        if (wea_w[g]) begin
          if (wr_first[g] < 0) wr_first[g] = c;
          if (addra_w[g] != 4'(wr_cnt[g] % 16)) wr_bad[g]++;
          wr_cnt[g]++;
        end
        if (rd_valid_w[g]) begin
          chk(tg("rd_data", g), int'(rd_data_w[g]), int'(exp_dat[rv_cnt[g] % 16]));
          if (first_rv[g] < 0) first_rv[g] = c;
          last_rv[g] = c;
          rv_cnt[g]++;
        end
        if (done_w[g]) begin
          if (done_at1[g] < 0) done_at1[g] = c;
          else                 done_at2[g] = c;
          done_cnt[g]++;
          if (rd_valid_w[g]) overlap[g]++;
        end
        if (c == 8 && (clr < 0 || clr > 8)) chk(tg("busy_mid", g), int'(busy_w[g]), 1);
        if (c == clr) begin
          chk(tg("clr_wea", g), int'(wea_w[g]), 0);
          chk(tg("clr_addra", g), int'(addra_w[g]), 0);
          chk(tg("clr_busy", g), int'(busy_w[g]), 0);
          chk(tg("clr_err", g), int'(err_cnt_w[g]), 0);
        end
        if (hold > 0 && c == 34 + lg) chk(tg("b2b_hold", g), int'(err_cnt_w[g]), exp_err);
        if (hold > 0 && c == 35 + lg) chk(tg("b2b_clr", g), int'(err_cnt_w[g]), 0);
      end
    end
    start = 1'b0;
    Clear = 1'b0;
  endtask

  task automatic verify_scan(input int nd);
    for (int g = 0; g < NI; g++) begin
      int lg;
      lg = lat_of(g);
      chk(tg("wr_cnt", g), wr_cnt[g], 16 * nd);
      chk(tg("wr_order", g), wr_bad[g], 0);
      chk(tg("wr_first", g), wr_first[g], 0);
      chk(tg("rv_cnt", g), rv_cnt[g], 16 * nd);
      chk(tg("first_rv", g), first_rv[g], 17 + lg);
      chk(tg("done_cnt", g), done_cnt[g], nd);
      chk(tg("done_at", g), done_at1[g], 33 + lg);
      if (nd == 2) chk(tg("done_at2", g), done_at2[g], 68 + 2 * lg);
      chk(tg("last_rv", g), last_rv[g], ((nd == 2) ? done_at2[g] : done_at1[g]) - 1);
      chk(tg("overlap", g), overlap[g], 0);
      chk(tg("err_cnt", g), int'(err_cnt_w[g]), exp_err);
      if (exp_err != 0) chk(tg("first_err", g), int'(fea_w[g]), exp_first);
      chk(tg("rd_last", g), int'(rd_data_w[g]), int'(exp_dat[15]));
      chk(tg("busy_end", g), int'(busy_w[g]), 0);
    end
  endtask

  task automatic verify_clear(input int clr);
    for (int g = 0; g < NI; g++) begin
      int lg;
      lg = lat_of(g);
      chk(tg("clr_done_cnt", g), done_cnt[g], 0);
      chk(tg("clr_wr_cnt", g), wr_cnt[g], (clr < 16) ? clr : 16);
      chk(tg("clr_rv_cnt", g), rv_cnt[g], (clr > 17 + lg) ? clr - 17 - lg : 0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    Clear = 1'b1;
    start = 1'b0;
    set_faults(0);
    repeat (2) @(posedge Clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk(tg("rst_wea", g), int'(wea_w[g]), 0);
      chk(tg("rst_addra", g), int'(addra_w[g]), 0);
      chk(tg("rst_rd_data", g), int'(rd_data_w[g]), 0);
      chk(tg("rst_rd_valid", g), int'(rd_valid_w[g]), 0);
      chk(tg("rst_busy", g), int'(busy_w[g]), 0);
      chk(tg("rst_done", g), int'(done_w[g]), 0);
      chk(tg("rst_err", g), int'(err_cnt_w[g]), 0);
      chk(tg("rst_fea", g), int'(fea_w[g]), 0);
    end
    Clear = 1'b0;

    run(45, 0, -1, -1, -1);  verify_scan(1);
    set_faults(1);
    run(45, 0, 3, 20, -1);   verify_scan(1);
    set_faults(0);
    run(45, 0, -1, -1, 0);   verify_clear(0);
    run(45, 0, -1, -1, 10);  verify_clear(10);
    run(45, 0, -1, -1, -1);  verify_scan(1);
    set_faults(2);
    run(45, 0, -1, -1, 25);  verify_clear(25);
    run(45, 0, -1, -1, -1);  verify_scan(1);
    set_faults(1);
    run(80, 39, -1, -1, -1); verify_scan(2);
    for (int i = 0; i < 4; i++) begin
      set_faults(2);
      run(45, 0, -1, -1, -1);
      verify_scan(1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_scan_ctrl.md
Name: bram_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 16x8 block-RAM wrapper. It drives the RAM's clka/wea/addra, and it consumes douta.
- On a start pulse it writes the fixed data pattern to every address.
- It then reads every address back in a pipelined sweep and presents each returned byte on a registered output.
- It compares each byte against the pattern and reports a mismatch count and the first failing address.
- It is a bring-up/self-test stage for the BRAM, and its rd_data output feeds the 8-bit register stage.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LAT, 2, cycles from addra presented to douta valid; legal range 1..4.
- PATTERN, 8'hAA, expected data; this is the value the RAM wrapper hard-wires on dina.

Ports:
- Clk  in  1  single clock; also drives the RAM's clka.
- Clear  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a scan; sampled only in IDLE.
- wea  out  1  RAM write enable.
- addra  out  ADDR_W  RAM address.
- douta  in  DATA_W  RAM read data.
- rd_data  out  DATA_W  last byte captured from the RAM.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at scan completion.
- err_cnt  out  ADDR_W+1  number of mismatching addresses in the last scan.
- first_err_addr  out  ADDR_W  address of the first mismatch; valid when err_cnt != 0.

Behaviour:
- Clock and reset: one clock, Clk. Clear is synchronous and active-high. All outputs are registered.
- Reset values: wea=0, addra=0, rd_data=0, rd_valid=0, busy=0, done=0, err_cnt=0, first_err_addr=0, FSM=IDLE, latency pipe cleared.
- State IDLE:
  - Outputs wea=0, busy=0.
  - start=1 moves to WRITE, loads addra=0, and clears err_cnt and first_err_addr.
- State WRITE:
  - wea=1; addra counts 0..2**ADDR_W-1, one address per cycle.
  - After the cycle with addra = max, go to READ with addra=0 and wea=0.
  - Lasts exactly 2**ADDR_W cycles.
- State READ:
  - wea=0; one address is issued per cycle, 0..max.
  - Each issued address enters a tag pipe of depth RD_LAT as {valid, addr}.
  - After max is issued, go to DRAIN.
- State DRAIN:
  - No new issues; addra holds the last value.
  - Stays until the tag pipe is empty, then goes to DONE.
- Tag handling (READ or DRAIN):
  - When a valid tag exits the pipe: rd_data <= douta, rd_valid=1 for that cycle.
  - If douta != PATTERN: err_cnt increments; if err_cnt was 0, first_err_addr <= tag addr.
  - err_cnt cannot overflow, since its maximum value is 2**ADDR_W.
- State DONE:
  - Lasts one cycle: done=1, busy=0 on the next edge, then IDLE.
  - err_cnt, first_err_addr and rd_data hold until the next accepted start or Clear.
- Scan latency: start accepted at edge 0 → first rd_valid at edge 2**ADDR_W + RD_LAT + 1 → done at edge 2*(2**ADDR_W) + RD_LAT + 1.
  - Defaults: first rd_valid at 19, done at 35.
  - Exactly 2**ADDR_W rd_valid pulses occur per scan, in ascending address order.
- start outside IDLE (including in DONE) is ignored; no queuing.
- Clear mid-scan: on the next edge all state returns to reset values, wea drops to 0, and the tag pipe is flushed. No done pulse is produced.
- Clear and start in the same cycle: Clear wins.
- rd_valid and done never assert in the same cycle; the last rd_valid precedes done by exactly 1 cycle.

Decomposition:
- Shared package: FSM state enum (IDLE, WRITE, READ, DRAIN, DONE) and default constants ADDR_W=4, DATA_W=8, RD_LAT=2, PATTERN=8'hAA. The RAM wrapper's dina value references the package PATTERN.
- One sub-module: rd_lat_pipe.
  - Parameterised shift register of RD_LAT stages carrying {valid, addr}.
  - Synchronous Clear.
  - Outputs the tail tag and a pipe-empty flag.

Test Plan:
- Nominal: Clear 2 cycles, then start 1 cycle, with a bench RAM model of RD_LAT=2 → 16 write cycles with wea=1 and addra 0..15; 16 rd_valid pulses, each with rd_data=8'hAA; err_cnt=0; done at edge 35; busy low afterward.
- Fault injection: the RAM model returns 8'h2A at addresses 5 and 12 → err_cnt=2, first_err_addr=5, rd_data=8'hAA after the final read.
- start asserted again at cycles 3 and 20 of a running scan → ignored; exactly one done pulse; cycle count unchanged (35).
- Clear at cycle 10 (mid-WRITE) and at cycle 25 (mid-READ) → next edge: wea=0, addra=0, busy=0, no done pulse; a following start runs a complete clean scan.
- RD_LAT=1 and RD_LAT=4 builds → first rd_valid at edges 18 and 21, done at 34 and 37; data aligned to the correct addresses (model returns addr-dependent data, compare the first_err_addr value).
- Back-to-back: start in the cycle after done → accepted; err_cnt cleared to 0 at acceptance; second scan identical to the first.
